tpu_mem_responder: RTL and testbench

Synthesizable single-bank matrix buffer that answers one TPU memory port (A, B or P), i.e. the responder for the `en/we/addr/word` interface the TPU drives. Three instances sit beside the `tpu` core. A host-side command/response stream fills and drains the bank while the TPU is idle. The TPU port has absolute priority and is never stalled.

---
 rtl/tpu_mem_responder_if.sv | 39 +++
 rtl/tpu_mem_responder.sv | 114 +++++++++++
 tb/tb_tpu_mem_responder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_mem_responder_if.sv
// TPU memory port plus host command/response stream for one matrix bank.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

interface tpu_mem_responder_if #(
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int WORD_WIDTH = `WORD_WIDTH
);
   logic                  en;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WORD_WIDTH-1:0] wdata;
   logic [WORD_WIDTH-1:0] rdata;
   logic                  lock;
   logic                  host_valid;
   logic                  host_ready;
   logic                  host_we;
   logic [ADDR_WIDTH-1:0] host_addr;
   logic [WORD_WIDTH-1:0] host_wdata;
   logic                  host_rvalid;
   logic                  host_rready;
   logic [WORD_WIDTH-1:0] host_rdata;

   modport master (
      output en, we, addr, wdata, lock,
      output host_valid, host_we, host_addr, host_wdata, host_rready,
      input  rdata, host_ready, host_rvalid, host_rdata
   );

   modport slave (
      input  en, we, addr, wdata, lock,
      input  host_valid, host_we, host_addr, host_wdata, host_rready,
      output rdata, host_ready, host_rvalid, host_rdata
   );
endinterface

// File: rtl/tpu_mem_responder.sv
// Single-port matrix bank serving a TPU port (1-cycle registered reads, never stalled) and a host stream.
// Host commands stall while TPU is enabled/locked or the one-deep response is unconsumed.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module tpu_mem_responder #(
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int WORD_WIDTH = `WORD_WIDTH,
   parameter int DEPTH      = 4096
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   tpu_mem_responder_if.slave     bus,
   input  logic                   cnt_clr_i,
   output logic [15:0]            tpu_rd_cnt_o,
   output logic [15:0]            tpu_wr_cnt_o,
   output logic                   err_o
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   logic [WORD_WIDTH-1:0] mem [DEPTH];

   logic                  host_ready;
   logic                  host_fire;
   logic                  tpu_rd;
   logic                  tpu_wr;
   logic                  host_rd;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WORD_WIDTH-1:0] mem_wdata;
   logic                  mem_we;
   logic                  in_range;
   logic [IDX_W-1:0]      idx;
   logic [WORD_WIDTH-1:0] rd_word;

   logic [WORD_WIDTH-1:0] rdata_q;
   logic                  host_rvalid_q;
   logic [WORD_WIDTH-1:0] host_rdata_q;
   logic [15:0]           rd_cnt_q;
   logic [15:0]           wr_cnt_q;
   logic                  err_q;

   // The TPU owns the single memory port whenever en is high; the host only gets idle cycles.
   assign host_ready = !bus.lock && !bus.en && !(host_rvalid_q && !bus.host_rready);
   assign host_fire  = bus.host_valid && host_ready;
   assign tpu_rd     = bus.en && !bus.we;
   assign tpu_wr     = bus.en && bus.we;
   assign host_rd    = host_fire && !bus.host_we;

   assign mem_addr  = bus.en ? bus.addr  : bus.host_addr;
   assign mem_wdata = bus.en ? bus.wdata : bus.host_wdata;
   assign mem_we    = tpu_wr || (host_fire && bus.host_we);
   assign in_range  = {1'b0, mem_addr} < DEPTH_W;
   assign idx       = mem_addr[IDX_W-1:0];
   assign rd_word   = in_range ? mem[idx] : '0;

   always_ff @(posedge clk_i) begin
      if (mem_we && in_range) begin
         mem[idx] <= mem_wdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q       <= '0;
         host_rvalid_q <= 1'b0;
         host_rdata_q  <= '0;
      end else begin
         if (tpu_rd) begin
            rdata_q <= rd_word;
         end
         // A new read accepted in the same cycle the old response drains keeps rvalid high.
         if (host_rd) begin
            host_rdata_q  <= rd_word;
            host_rvalid_q <= 1'b1;
         end else if (bus.host_rready) begin
            host_rvalid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (cnt_clr_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
         end else begin
            if (tpu_rd) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (tpu_wr) wr_cnt_q <= wr_cnt_q + 16'd1;
         end
         if ((bus.en || host_fire) && !in_range) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.rdata       = rdata_q;
   assign bus.host_ready  = host_ready;
   assign bus.host_rvalid = host_rvalid_q;
   assign bus.host_rdata  = host_rdata_q;
   assign tpu_rd_cnt_o    = rd_cnt_q;
   assign tpu_wr_cnt_o    = wr_cnt_q;
   assign err_o           = err_q;

endmodule

// File: tb/tb_tpu_mem_responder.sv
// Directed bench: a full-depth bank and a 256-word bank driven with identical stimulus.
module tb_tpu_mem_responder;

   logic        clk_i;
   logic        rst_ni;
   logic        cnt_clr_i;
   logic [15:0] rd_cnt_a, wr_cnt_a, rd_cnt_b, wr_cnt_b;
   logic        err_a, err_b;
   int          n_vec;
   int          n_err;
   int          exp_rd;
   int          exp_wr;

   tpu_mem_responder_if #(.ADDR_WIDTH(12), .WORD_WIDTH(16)) bus_a ();
   tpu_mem_responder_if #(.ADDR_WIDTH(12), .WORD_WIDTH(16)) bus_b ();

   assign bus_b.en          = bus_a.en;
   assign bus_b.we          = bus_a.we;
   assign bus_b.addr        = bus_a.addr;
   assign bus_b.wdata       = bus_a.wdata;
   assign bus_b.lock        = bus_a.lock;
   assign bus_b.host_valid  = bus_a.host_valid;
   assign bus_b.host_we     = bus_a.host_we;
   assign bus_b.host_addr   = bus_a.host_addr;
   assign bus_b.host_wdata  = bus_a.host_wdata;
   assign bus_b.host_rready = bus_a.host_rready;

   tpu_mem_responder #(.ADDR_WIDTH(12), .WORD_WIDTH(16), .DEPTH(4096)) u_dut_a (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .bus          (bus_a),
      .cnt_clr_i    (cnt_clr_i),
      .tpu_rd_cnt_o (rd_cnt_a),
      .tpu_wr_cnt_o (wr_cnt_a),
      .err_o        (err_a)
   );

   tpu_mem_responder #(.ADDR_WIDTH(12), .WORD_WIDTH(16), .DEPTH(256)) u_dut_b (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .bus          (bus_b),
      .cnt_clr_i    (cnt_clr_i),
      .tpu_rd_cnt_o (rd_cnt_b),
      .tpu_wr_cnt_o (wr_cnt_b),
      .err_o        (err_b)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      n_vec = 0; n_err = 0; exp_rd = 0; exp_wr = 0;
      rst_ni = 1'b0; cnt_clr_i = 1'b0;
      bus_a.en = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
      bus_a.lock = 1'b0; bus_a.host_valid = 1'b0; bus_a.host_we = 1'b0;
      bus_a.host_addr = '0; bus_a.host_wdata = '0; bus_a.host_rready = 1'b0;
      #2;
      chk("rst_rdata", 32'(bus_a.rdata), 0);
      chk("rst_rvalid", 32'(bus_a.host_rvalid), 0);
      chk("rst_hrdata", 32'(bus_a.host_rdata), 0);
      chk("rst_rdcnt", 32'(rd_cnt_a), 0);
      chk("rst_wrcnt", 32'(wr_cnt_a), 0);
      chk("rst_err", 32'(err_a), 0);
      rst_ni = 1'b1;
      tick();

      // Host fill, then TPU streams the words back
      for (int i = 0; i < 10; i++) begin
         bus_a.host_valid = 1'b1; bus_a.host_we = 1'b1;
         bus_a.host_addr = 12'(i); bus_a.host_wdata = 16'(i * 3);
         #1 chk("fill_rdy", 32'(bus_a.host_ready), 1);
         tick();
      end
      bus_a.host_valid = 1'b0;
      bus_a.lock = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus_a.en = 1'b1; bus_a.we = 1'b0; bus_a.addr = 12'(i);
         tick();
         exp_rd++;
         chk("stream_rd", 32'(bus_a.rdata), 32'(i * 3));
      end
      bus_a.en = 1'b0;
      chk("stream_rdcnt", 32'(rd_cnt_a), 10);

      // TPU write + read-after-write, then host drains it
      bus_a.en = 1'b1; bus_a.we = 1'b1; bus_a.addr = 12'h200; bus_a.wdata = 16'hA5A5;
      tick(); exp_wr++;
      bus_a.we = 1'b0;
      tick(); exp_rd++;
      chk("raw_rd", 32'(bus_a.rdata), 32'hA5A5);
      bus_a.en = 1'b0; bus_a.lock = 1'b0;
      bus_a.host_valid = 1'b1; bus_a.host_we = 1'b0; bus_a.host_addr = 12'h200;
      tick();
      bus_a.host_valid = 1'b0;
      chk("drain_rvalid", 32'(bus_a.host_rvalid), 1);
      chk("drain_data", 32'(bus_a.host_rdata), 32'hA5A5);
      chk("oor_host_data", 32'(bus_b.host_rdata), 0);
      chk("oor_host_err", 32'(err_b), 1);
      chk("inrange_err", 32'(err_a), 0);
      chk("drain_wrcnt", 32'(wr_cnt_a), 32'(exp_wr));
      bus_a.host_rready = 1'b1;
      tick();
      chk("drain_done", 32'(bus_a.host_rvalid), 0);
      bus_a.host_rready = 1'b0;

      // TPU priority over a held host command
      bus_a.host_valid = 1'b1; bus_a.host_we = 1'b1; bus_a.host_addr = 12'd5; bus_a.host_wdata = 16'h55;
      bus_a.en = 1'b1; bus_a.we = 1'b0; bus_a.addr = '0;
      #1 chk("prio_rdy0", 32'(bus_a.host_ready), 0);
      tick(); exp_rd++;
      bus_a.en = 1'b0;
      #1 chk("prio_rdy1", 32'(bus_a.host_ready), 1);
      tick();
      bus_a.en = 1'b1;
      #1 chk("prio_rdy2", 32'(bus_a.host_ready), 0);
      tick(); exp_rd++;
      bus_a.en = 1'b0;
      bus_a.host_we = 1'b0;
      tick();
      bus_a.host_valid = 1'b0;
      chk("prio_wdata", 32'(bus_a.host_rdata), 32'h55);
      bus_a.host_rready = 1'b1;
      tick();
      bus_a.host_rready = 1'b0;
      bus_a.lock = 1'b1; bus_a.host_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("lock_rdy", 32'(bus_a.host_ready), 0);
         tick();
      end
      bus_a.lock = 1'b0;
      bus_a.host_we = 1'b1; bus_a.host_addr = 12'd7; bus_a.host_wdata = 16'h77;
      tick();
      bus_a.host_we = 1'b0;
      tick();
      bus_a.host_valid = 1'b0;
      chk("hwr_hrd", 32'(bus_a.host_rdata), 32'h77);
      bus_a.host_rready = 1'b1;
      tick();
      bus_a.host_rready = 1'b0;

      // Response backpressure, second read accepted as first drains
      bus_a.host_valid = 1'b1; bus_a.host_we = 1'b0; bus_a.host_addr = 12'd3;
      #1 chk("bp_rdy_a", 32'(bus_a.host_ready), 1);
      tick();
      bus_a.host_addr = 12'd4;
      #1 chk("bp_rdy_b", 32'(bus_a.host_ready), 0);
      chk("bp_first", 32'(bus_a.host_rdata), 9);
      tick();
      chk("bp_rdy_c", 32'(bus_a.host_ready), 0);
      chk("bp_hold", 32'(bus_a.host_rdata), 9);
      bus_a.host_rready = 1'b1;
      #1 chk("bp_rdy_d", 32'(bus_a.host_ready), 1);
      tick();
      bus_a.host_valid = 1'b0;
      chk("bp_rvalid", 32'(bus_a.host_rvalid), 1);
      chk("bp_second", 32'(bus_a.host_rdata), 12);
      tick();
      chk("bp_empty", 32'(bus_a.host_rvalid), 0);
      bus_a.host_rready = 1'b0;

      // Async reset with a pending response; memory survives
      bus_a.host_valid = 1'b1; bus_a.host_addr = 12'd7;
      tick();
      bus_a.host_valid = 1'b0;
      chk("pend_rvalid", 32'(bus_a.host_rvalid), 1);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_rdata", 32'(bus_a.rdata), 0);
      chk("arst_rvalid", 32'(bus_a.host_rvalid), 0);
      chk("arst_hrdata", 32'(bus_a.host_rdata), 0);
      chk("arst_rdcnt", 32'(rd_cnt_a), 0);
      chk("arst_wrcnt", 32'(wr_cnt_a), 0);
      chk("arst_err_b", 32'(err_b), 0);
      #2 rst_ni = 1'b1;
      exp_rd = 0; exp_wr = 0;
      tick();
      bus_a.host_valid = 1'b1; bus_a.host_addr = 12'd3;
      tick();
      bus_a.host_valid = 1'b0;
      chk("retain", 32'(bus_a.host_rdata), 9);
      bus_a.host_rready = 1'b1;
      tick();
      bus_a.host_rready = 1'b0;

      // TPU out-of-range on the 256-word bank
      bus_a.lock = 1'b1;
      bus_a.en = 1'b1; bus_a.we = 1'b1; bus_a.addr = 12'h000; bus_a.wdata = 16'h1234;
      tick(); exp_wr++;
      bus_a.addr = 12'h100; bus_a.wdata = 16'hDEAD;
      tick(); exp_wr++;
      bus_a.we = 1'b0;
      tick(); exp_rd++;
      chk("oor_rd", 32'(bus_b.rdata), 0);
      chk("oor_err", 32'(err_b), 1);
      chk("big_rd", 32'(bus_a.rdata), 32'hDEAD);
      chk("big_err", 32'(err_a), 0);
      bus_a.addr = 12'h000;
      tick(); exp_rd++;
      chk("oor_alias", 32'(bus_b.rdata), 32'h1234);
      bus_a.en = 1'b0;
      tick();
      chk("oor_sticky", 32'(err_b), 1);
      chk("oor_rdcnt", 32'(rd_cnt_b), 32'(exp_rd));
      chk("oor_wrcnt", 32'(wr_cnt_b), 32'(exp_wr));

      // Clear wins over a same-cycle increment
      bus_a.en = 1'b1; bus_a.we = 1'b0; cnt_clr_i = 1'b1;
      tick();
      chk("clr_rd", 32'(rd_cnt_a), 0);
      chk("clr_wr", 32'(wr_cnt_a), 0);
      cnt_clr_i = 1'b0;
      tick();
      chk("clr_inc", 32'(rd_cnt_a), 1);
      bus_a.en = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
